// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer slice.
package serializer_pkg;

   // FSM states; ST_ prefix keeps the literals clear of the GAP parameter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_GAP   = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_GAP   = 0;
   localparam int GAP_CNT_W     = 4;   // holds gap counts 0..15

   // Bit-counter width; never narrower than one bit.
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word in, serial bit out bundle between producer and serializer.
interface bit_serializer_if
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic             busy;

   modport master (output din, din_valid, input din_ready, x, x_valid, busy);
   modport slave  (input din, din_valid, output din_ready, x, x_valid, busy);
endinterface

// File: rtl/piso_shifter.sv
// Load/shift register with bit-order selection. q_bit is itself a flop:
// it takes the head bit on load/shift and falls back to the idle level
// whenever neither is requested, so the serial output needs no extra gating.
module piso_shifter #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q_bit
);
   // sr holds the bits not yet presented on q_bit
   logic [WIDTH-1:0] sr;

   // Present the next head bit and drop it from the remaining-bits register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr    <= '0;
         q_bit <= IDLE_LEVEL;
      end else if (load) begin
         if (MSB_FIRST) begin
            q_bit <= d[WIDTH-1];
            sr    <= {d[WIDTH-2:0], 1'b0};
         end else begin
            q_bit <= d[0];
            sr    <= {1'b0, d[WIDTH-1:1]};
         end
      end else if (shift) begin
         if (MSB_FIRST) begin
            q_bit <= sr[WIDTH-1];
            sr    <= {sr[WIDTH-2:0], 1'b0};
         end else begin
            q_bit <= sr[0];
            sr    <= {1'b0, sr[WIDTH-1:1]};
         end
      end else begin
         q_bit <= IDLE_LEVEL;
      end
   end
endmodule

// File: rtl/bit_serializer.sv
// Parallel-in serial-out stage feeding the sequence detector: word handshake,
// bit/gap counting FSM and registered x / x_valid / busy outputs.
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP        = DEFAULT_GAP,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   bit_serializer_if.slave   bus
);
   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0]        LAST_BIT = CW'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

   state_t                 state, state_nxt;
   logic [CW-1:0]          bcnt, bcnt_nxt;
   logic [GAP_CNT_W-1:0]   gcnt, gcnt_nxt;
   logic                   load, shift;
   logic                   last, ready, hs;
   logic                   xv_q, busy_q, q_bit;

   assign last  = (state == ST_SHIFT) && (bcnt == LAST_BIT);
   // Ready in IDLE, and on the final bit only when words may run back-to-back.
   assign ready = (state == ST_IDLE) || ((GAP == 0) && last);
   assign hs    = bus.din_valid && ready;

   // Next-state, counters and shifter controls.
   always_comb begin
      state_nxt = state;
      bcnt_nxt  = bcnt;
      gcnt_nxt  = gcnt;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hs) begin
               load      = 1'b1;
               bcnt_nxt  = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!last) begin
               shift    = 1'b1;
               bcnt_nxt = bcnt + 1'b1;
            end else begin
               bcnt_nxt = '0;
               if (GAP > 0) begin
                  gcnt_nxt  = '0;
                  state_nxt = ST_GAP;
               end else if (hs) begin
                  load = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gcnt == GAP_LAST) begin
               gcnt_nxt  = '0;
               state_nxt = ST_IDLE;
            end else begin
               gcnt_nxt = gcnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         bcnt   <= '0;
         gcnt   <= '0;
         xv_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         bcnt   <= bcnt_nxt;
         gcnt   <= gcnt_nxt;
         xv_q   <= (state_nxt == ST_SHIFT);
         busy_q <= (state_nxt != ST_IDLE);
      end
   end

   piso_shifter #(
      .WIDTH      (WIDTH),
      .MSB_FIRST  (MSB_FIRST),
      .IDLE_LEVEL (IDLE_LEVEL)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .d     (bus.din),
      .q_bit (q_bit)
   );

   assign bus.din_ready = ready;
   assign bus.x         = q_bit;
   assign bus.x_valid   = xv_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations (MSB/GAP0, LSB/GAP0,
// MSB/GAP2 with idle level 1) checked every cycle against a queue model,
// plus directed literal checks of the serial patterns.
module tb_bit_serializer;
   logic clk;
   logic rst = 1'b1;
   logic chk_on = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [7:0] dn [3];
   logic       dv [3];
   logic       xo [3];
   logic       xvo[3];
   logic       bo [3];
   logic       ro [3];

   bit_serializer_if #(.WIDTH(8)) if0 ();
   bit_serializer_if #(.WIDTH(8)) if1 ();
   bit_serializer_if #(.WIDTH(8)) if2 ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0))
      u0 (.clk(clk), .rst(rst), .bus(if0));
   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_LEVEL(1'b0))
      u1 (.clk(clk), .rst(rst), .bus(if1));
   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2), .IDLE_LEVEL(1'b1))
      u2 (.clk(clk), .rst(rst), .bus(if2));

   assign if0.din = dn[0];  assign if0.din_valid = dv[0];
   assign if1.din = dn[1];  assign if1.din_valid = dv[1];
   assign if2.din = dn[2];  assign if2.din_valid = dv[2];
   assign xo[0] = if0.x;  assign xvo[0] = if0.x_valid;  assign bo[0] = if0.busy;  assign ro[0] = if0.din_ready;
   assign xo[1] = if1.x;  assign xvo[1] = if1.x_valid;  assign bo[1] = if1.busy;  assign ro[1] = if1.din_ready;
   assign xo[2] = if2.x;  assign xvo[2] = if2.x_valid;  assign bo[2] = if2.busy;  assign ro[2] = if2.din_ready;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int gap_of(input int d);  return (d == 2) ? 2 : 0;     endfunction
   function automatic bit msb_of(input int d);  return (d != 1);             endfunction
   function automatic bit idle_of(input int d); return (d == 2);             endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Model: each DUT is a queue of bits still to appear on x plus a count of
   // remaining gap cycles; the front of the queue is what x shows this cycle.
   bit mq[3][$];
   int gl[3];

   function automatic bit m_ready(input int d);
      return ((mq[d].size() == 0) && (gl[d] == 0)) ||
             ((gap_of(d) == 0) && (mq[d].size() == 1));
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         for (int d = 0; d < 3; d++) begin
            if (!rst) begin
               mq[d].delete();
               gl[d] = 0;
            end else begin
               bit         hs;
               logic [7:0] w;
               hs = dv[d] && m_ready(d);
               w  = dn[d];
               if (mq[d].size() > 0) begin
                  void'(mq[d].pop_front());
                  if ((mq[d].size() == 0) && (gap_of(d) > 0)) gl[d] = gap_of(d);
               end else if (gl[d] > 0) begin
                  gl[d]--;
               end
               if (hs)
                  for (int i = 0; i < 8; i++)
                     mq[d].push_back(msb_of(d) ? w[7-i] : w[i]);
            end
         end
      end
   end

   // Every-cycle compare of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
               bit ev, ex, eb;
               ev = (mq[d].size() > 0);
               ex = ev ? mq[d][0] : idle_of(d);
               eb = ev || (gl[d] > 0);
               chk($sformatf("d%0d_x_valid", d), 32'(xvo[d]), 32'(ev));
               chk($sformatf("d%0d_x", d),       32'(xo[d]),  32'(ex));
               chk($sformatf("d%0d_busy", d),    32'(bo[d]),  32'(eb));
               chk($sformatf("d%0d_din_ready", d), 32'(ro[d]), 32'(m_ready(d)));
            end
         end
      end
   end

   logic [31:0] xs, vs, rs;
   task automatic clr_cap;
      xs = '0; vs = '0; rs = '0;
   endtask
   task automatic take(input int d);
      xs = {xs[30:0], xo[d]};
      vs = {vs[30:0], xvo[d]};
      rs = {rs[30:0], ro[d]};
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         dv[d] = 1'b0;
         dn[d] = 8'h00;
      end
      #2 rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_x_valid%0d", d), 32'(xvo[d]), 32'(0));
         chk($sformatf("rst_x%0d", d),       32'(xo[d]),  32'(idle_of(d)));
         chk($sformatf("rst_busy%0d", d),    32'(bo[d]),  32'(0));
      end
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk($sformatf("rst_ready%0d", d), 32'(ro[d]), 32'(1));

      // single word, MSB first
      @(posedge clk); #1 dn[0] = 8'hA5; dv[0] = 1'b1;
      @(posedge clk); #1 dv[0] = 1'b0; dn[0] = 8'h00;
      clr_cap();
      repeat (8) begin @(negedge clk); take(0); end
      chk("t1_bits",  32'(xs[7:0]), 32'(8'hA5));
      chk("t1_valid", 32'(vs[7:0]), 32'(8'hFF));
      @(negedge clk);
      chk("t1_idle_x",  32'(xo[0]),  32'(0));
      chk("t1_idle_xv", 32'(xvo[0]), 32'(0));
      chk("t1_idle_rdy", 32'(ro[0]), 32'(1));

      // single word, LSB first
      repeat (2) @(posedge clk);
      #1 dn[1] = 8'hC1; dv[1] = 1'b1;
      @(posedge clk); #1 dv[1] = 1'b0;
      clr_cap();
      repeat (8) begin @(negedge clk); take(1); end
      chk("t2_bits",  32'(xs[7:0]), 32'(8'h83));
      chk("t2_valid", 32'(vs[7:0]), 32'(8'hFF));

      // back-to-back, GAP=0
      repeat (2) @(posedge clk);
      #1 dn[0] = 8'hA5; dv[0] = 1'b1;
      @(posedge clk); #1 dn[0] = 8'h3C;
      clr_cap();
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk); take(0);
         if (i == 8) begin @(posedge clk); #1 dv[0] = 1'b0; end
      end
      chk("t3_bits",  32'(xs[15:0]), 32'(16'hA53C));
      chk("t3_valid", 32'(vs[15:0]), 32'(16'hFFFF));
      chk("t3_ready", 32'(rs[15:0]), 32'(16'h0101));

      // gap insertion, GAP=2, idle level 1, two words offered continuously
      repeat (2) @(posedge clk);
      #1 dn[2] = 8'hA5; dv[2] = 1'b1;
      @(posedge clk); #1 dn[2] = 8'h3C;
      clr_cap();
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk); take(2);
         if (i == 11) begin @(posedge clk); #1 dv[2] = 1'b0; end
      end
      chk("t4_bits",  32'(xs[18:0]), 32'({8'hA5, 3'b111, 8'h3C}));
      chk("t4_valid", 32'(vs[18:0]), 32'({8'hFF, 3'b000, 8'hFF}));
      chk("t4_ready", 32'(rs[18:0]), 32'({10'b0, 1'b1, 8'b0}));

      // mid-word reset, then a clean word
      repeat (4) @(posedge clk);
      #1 dn[0] = 8'hFF; dv[0] = 1'b1;
      @(posedge clk); #1 dv[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_pre_xv", 32'(xvo[0]), 32'(1));
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("t5_async_xv",   32'(xvo[0]), 32'(0));
      chk("t5_async_x",    32'(xo[0]),  32'(0));
      chk("t5_async_busy", 32'(bo[0]),  32'(0));
      @(negedge clk); #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 dn[0] = 8'h81; dv[0] = 1'b1;
      @(posedge clk); #1 dv[0] = 1'b0;
      clr_cap();
      repeat (8) begin @(negedge clk); take(0); end
      chk("t5_bits",  32'(xs[7:0]), 32'(8'h81));
      chk("t5_valid", 32'(vs[7:0]), 32'(8'hFF));

      // din changing every cycle while busy; only the ready-edge word is sent
      repeat (2) @(posedge clk);
      #1 dn[0] = 8'h5A; dv[0] = 1'b1;
      @(posedge clk); #1 dn[0] = 8'hE7;
      clr_cap();
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk); take(0);
         if (i <= 6)      begin @(posedge clk); #1 dn[0] = 8'(8'h11 * i); end
         else if (i == 7) begin @(posedge clk); #1 dn[0] = 8'h96; end
         else if (i == 8) begin @(posedge clk); #1 dv[0] = 1'b0; dn[0] = 8'h00; end
      end
      chk("t6_bits",  32'(xs[15:0]), 32'(16'h5A96));
      chk("t6_valid", 32'(vs[15:0]), 32'(16'hFFFF));

      repeat (4) @(negedge clk);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
